ps2_mouse_rx: RTL



---
 rtl/ps2_mouse_pkg.sv | 33 +++
 rtl/ps2_line_filter.sv | 52 +++++
 rtl/ps2_mouse_rx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse receiver.
// Optional build macro: PS2_MOUSE_WHEEL_EN selects 4-byte IntelliMouse packets.
package ps2_mouse_pkg;

  // Per-byte frame receiver states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  // Width of the toggle-strobe bus consumed by paddle_ctl: {toggle, Y, X, status}.
  localparam int PKT_W = 25;

  // Bit positions inside the status byte (packet byte 0).
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF  = 6;
  localparam int YOVF  = 7;

  // Bytes per movement packet.
`ifdef PS2_MOUSE_WHEEL_EN
  localparam int PKT_BYTES = 4;
`else
  localparam int PKT_BYTES = 3;
`endif

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions the raw PS/2 clock line: 2-FF synchronizer, FILTER_LEN-sample
// debounce, and a one-cycle strobe on each falling edge of the filtered level.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic fall_strobe
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Two-stage synchronizer; idle PS/2 lines are high, so reset to 1.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= line_in;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce: flip the level after FILTER_LEN consecutive disagreeing samples;
  // a 1->0 flip raises the bit strobe for exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      level       <= 1'b1;
      cnt         <= '0;
      fall_strobe <= 1'b0;
    end else begin
      fall_strobe <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        level       <= sync_q2;
        cnt         <= '0;
        fall_strobe <= level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: decodes 11-bit device frames and assembles movement
// packets onto the toggle-strobe ps2_mouse bus {toggle, Y, X, status}.
// Optional build macro: PS2_MOUSE_WHEEL_EN adds a 4th (wheel) byte and the
// ps2_wheel output port.
module ps2_mouse_rx
  import ps2_mouse_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ps2_clk_in,
  input  logic             ps2_data_in,
  output logic [PKT_W-1:0] ps2_mouse,
  output logic             frame_err,
  output logic             busy
`ifdef PS2_MOUSE_WHEEL_EN
  ,
  output logic [7:0]       ps2_wheel
`endif
);

  localparam int         TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] LAST_IDX = 2'(PKT_BYTES - 1);

  logic             strobe;
  logic             data_q1;
  logic             data_q2;

  frame_state_t     state,   state_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift_q, shift_n;
  logic             par_q,   par_n;
  logic [1:0]       idx_q,   idx_n;
  logic             err_n;
  logic             store_byte;
  logic             publish;

  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_hit;

  logic [7:0]       b0;
  logic [7:0]       b1;
`ifdef PS2_MOUSE_WHEEL_EN
  logic [7:0]       b2;
`endif

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk         (clk),
    .reset       (reset),
    .line_in     (ps2_clk_in),
    .fall_strobe (strobe)
  );

  // Data line only needs synchronizing; it is stable for the whole clock-low phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q1 <= 1'b1;
      data_q2 <= 1'b1;
    end else begin
      data_q1 <= ps2_data_in;
      data_q2 <= data_q1;
    end
  end

  assign busy        = (state != ST_IDLE) || (idx_q != 2'd0);
  assign timeout_hit = busy && !strobe && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts idle cycles between strobes while a frame/packet is open.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (strobe || timeout_hit || !busy) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Next-state logic for the frame FSM and the packet byte index.
  // NOTE: every signal driven here gets a default first, otherwise synthesis infers latches.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift_q;
    par_n      = par_q;
    idx_n      = idx_q;
    err_n      = 1'b0;
    store_byte = 1'b0;
    publish    = 1'b0;

    if (strobe) begin
      case (state)
        ST_IDLE: begin
          if (!data_q2) begin
            state_n   = ST_DATA;
            bit_cnt_n = 3'd0;
            par_n     = 1'b0;
          end
        end
        ST_DATA: begin
          shift_n   = {data_q2, shift_q[7:1]};
          par_n     = par_q ^ data_q2;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end
        ST_PARITY: begin
          // Odd parity: XOR of data plus parity bit must be 1.
          par_n   = par_q ^ data_q2;
          state_n = ST_STOP;
        end
        ST_STOP: begin
          state_n = ST_IDLE;
          if (!data_q2 || !par_q) begin
            err_n = 1'b1;
            idx_n = 2'd0;
          end else if ((idx_q == 2'd0) && !shift_q[SYNC]) begin
            err_n = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            publish = 1'b1;
            idx_n   = 2'd0;
          end else begin
            store_byte = 1'b1;
            idx_n      = idx_q + 2'd1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_n = ST_IDLE;
      idx_n   = 2'd0;
    end
  end

  // Control state and published outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      shift_q   <= 8'd0;
      par_q     <= 1'b0;
      idx_q     <= 2'd0;
      frame_err <= 1'b0;
      ps2_mouse <= '0;
`ifdef PS2_MOUSE_WHEEL_EN
      ps2_wheel <= 8'd0;
`endif
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift_q   <= shift_n;
      par_q     <= par_n;
      idx_q     <= idx_n;
      frame_err <= err_n;
      if (publish) begin
`ifdef PS2_MOUSE_WHEEL_EN
        ps2_mouse <= {~ps2_mouse[PKT_W-1], b2, b1, b0};
        ps2_wheel <= shift_q;
`else
        ps2_mouse <= {~ps2_mouse[PKT_W-1], shift_q, b1, b0};
`endif
      end
    end
  end

  // Partial-packet byte buffer.
  // NOTE: no reset needed; each slot is rewritten by the index sequence before it is ever published.
  always_ff @(posedge clk) begin
    if (store_byte) begin
      case (idx_q)
        2'd0:    b0 <= shift_q;
        2'd1:    b1 <= shift_q;
`ifdef PS2_MOUSE_WHEEL_EN
        2'd2:    b2 <= shift_q;
`endif
        default: ;
      endcase
    end
  end

endmodule
